qspi_rom_responder: RTL and testbench

//  Flash-side responder for the cartridge QSPI ROM link. It emulates a quad-I/O fast-read
//  (0xEB) NOR flash so the Atari 2600 core's flash controller can be exercised in simulation
//  and on FPGA without a physical PMOD. It decodes the command, address, mode and dummy

---
 rtl/qspi_rom_responder.sv | 198 +++++++++++++++++++
 tb/tb_qspi_rom_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_rom_responder.sv
// Flash-side responder that emulates a quad-I/O fast-read (0xEB) NOR flash in front of a
// synchronous byte memory. SCK is oversampled by clk; all SPI inputs are synchronized first.
module qspi_rom_responder #(
  parameter int         ADDR_BITS     = 24,
  parameter int         MEM_ADDR_BITS = 12,
  parameter int         DUMMY_CYCLES  = 4,
  parameter logic [7:0] CMD_READ      = 8'hEB,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_select,
  input  logic                     spi_clk_in,
  input  logic [3:0]               spi_data_in,
  output logic [3:0]               spi_data_out,
  output logic [3:0]               spi_data_oe,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic                     mem_read,
  input  logic [7:0]               mem_data,
  output logic                     continuous,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    MODE,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS / 4 - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES);

  state_t                         state;
  logic [SYNC_STAGES-1:0]         cs_sync;
  logic [SYNC_STAGES-1:0]         sck_sync;
  logic [SYNC_STAGES-1:0][3:0]    io_sync;
  logic                           cs_prev;
  logic                           sck_prev;
  logic                           cs_s;
  logic                           sck_s;
  logic [3:0]                     io_s;
  logic                           cs_fall;
  logic                           sck_rise;
  logic                           sck_fall;
  logic [7:0]                     cnt;
  logic [6:0]                     cmd_sr;
  logic [MEM_ADDR_BITS-1:0]       addr_sr;
  logic [3:0]                     mode_hi;
  logic                           low_next;
  logic                           fetch_q;
  logic [7:0]                     byte_q;

  // Sync flops reset low so a CS already low at reset release never looks like a fall;
  // the rest of an interrupted transaction is therefore ignored until CS returns high.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync  <= '0;
      sck_sync <= '0;
      io_sync  <= '0;
      cs_prev  <= 1'b0;
      sck_prev <= 1'b0;
    end else begin
      cs_sync[0]  <= spi_select;
      sck_sync[0] <= spi_clk_in;
      io_sync[0]  <= spi_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync[i]  <= cs_sync[i-1];
        sck_sync[i] <= sck_sync[i-1];
        io_sync[i]  <= io_sync[i-1];
      end
      cs_prev  <= cs_s;
      sck_prev <= sck_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign io_s     = io_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_prev & ~cs_s;
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign busy     = (state != IDLE);

  // Fetched byte lands one clk after the strobe; it is consumed only on later SCK falls.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_q <= 1'b0;
      byte_q  <= '0;
    end else begin
      fetch_q <= mem_read;
      if (fetch_q) byte_q <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      spi_data_out <= '0;
      spi_data_oe  <= '0;
      mem_addr     <= '0;
      mem_read     <= 1'b0;
      continuous   <= 1'b0;
      cnt          <= '0;
      cmd_sr       <= '0;
      addr_sr      <= '0;
      mode_hi      <= '0;
      low_next     <= 1'b0;
    end else begin
      mem_read <= 1'b0;
      if (cs_s) begin
        // CS high wins over any coincident SCK edge.
        state       <= IDLE;
        spi_data_oe <= '0;
        cnt         <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              cnt   <= '0;
              state <= continuous ? ADDR : CMD;
            end
          end
          CMD: begin
            if (sck_rise) begin
              cmd_sr <= {cmd_sr[5:0], io_s[0]};
              if (cnt == 8'd7) begin
                cnt   <= '0;
                state <= ({cmd_sr, io_s[0]} == CMD_READ) ? ADDR : IGNORE;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          ADDR: begin
            // Only the low MEM_ADDR_BITS survive the shift; higher address bits fall off.
            if (sck_rise) begin
              addr_sr <= {addr_sr[MEM_ADDR_BITS-5:0], io_s};
              if (cnt == ADDR_LAST) begin
                cnt   <= '0;
                state <= MODE;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          MODE: begin
            if (sck_rise) begin
              if (cnt == 8'd0) begin
                mode_hi <= io_s;
                cnt     <= 8'd1;
              end else begin
                continuous <= (mode_hi == 4'hA);
                mem_addr   <= addr_sr;
                mem_read   <= 1'b1;
                cnt        <= '0;
                state      <= DUMMY;
              end
            end
          end
          DUMMY: begin
            if (sck_rise && cnt != DUMMY_LAST) begin
              cnt <= cnt + 8'd1;
            end else if (sck_fall && cnt == DUMMY_LAST) begin
              spi_data_oe  <= 4'hF;
              spi_data_out <= byte_q[7:4];
              low_next     <= 1'b1;
              state        <= DATA;
            end
          end
          DATA: begin
            if (sck_fall) begin
              if (low_next) begin
                spi_data_out <= byte_q[3:0];
                mem_addr     <= mem_addr + 1'b1;
                mem_read     <= 1'b1;
                low_next     <= 1'b0;
              end else begin
                spi_data_out <= byte_q[7:4];
                low_next     <= 1'b1;
              end
            end
          end
          IGNORE: begin
            spi_data_oe <= '0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_rom_responder.sv
// Bench for qspi_rom_responder: acts as the QSPI controller and the backing byte memory.
module tb_qspi_rom_responder;

  logic        clk;
  logic        reset;
  logic        spi_select;
  logic        spi_clk_in;
  logic [3:0]  spi_data_in;
  logic [3:0]  spi_data_out;
  logic [3:0]  spi_data_oe;
  logic [11:0] mem_addr;
  logic        mem_read;
  logic [7:0]  mem_data;
  logic        continuous;
  logic        busy;

  logic [7:0]  rom [0:4095];
  logic [7:0]  exp_q [$];
  logic [3:0]  oe_or;
  logic        mr_or;
  int          checks;
  int          errors;

  typedef struct {
    logic        skip_cmd;
    logic [23:0] addr;
    logic [7:0]  mode;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] a1;
    logic        cont;
  } vec_t;

  vec_t vecs [5];

  qspi_rom_responder dut (
    .clk          (clk),
    .reset        (reset),
    .spi_select   (spi_select),
    .spi_clk_in   (spi_clk_in),
    .spi_data_in  (spi_data_in),
    .spi_data_out (spi_data_out),
    .spi_data_oe  (spi_data_oe),
    .mem_addr     (mem_addr),
    .mem_read     (mem_read),
    .mem_data     (mem_data),
    .continuous   (continuous),
    .busy         (busy)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_read) mem_data <= rom[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drivers: everything is driven and sampled on the falling clk edge
  task automatic wait_clk(input int n);
    repeat (n) begin
      @(negedge clk);
      oe_or = oe_or | spi_data_oe;
      mr_or = mr_or | mem_read;
    end
  endtask

  task automatic sck_pulse(input logic [3:0] io, input int gap);
    spi_data_in = io;
    spi_clk_in  = 1'b1;
    wait_clk(2 + gap);
    spi_clk_in  = 1'b0;
    wait_clk(2 + gap);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) sck_pulse({3'b000, c[i]}, 0);
  endtask

  task automatic send_addr(input logic [23:0] a, input int nibs);
    for (int i = 0; i < nibs; i++) sck_pulse(a[23 - 4*i -: 4], 0);
  endtask

  task automatic send_mode_dummy(input logic [7:0] m);
    sck_pulse(m[7:4], 0);
    sck_pulse(m[3:0], 0);
    for (int i = 0; i < 4; i++) sck_pulse(4'h0, 0);
  endtask

  task automatic read_nibble(input int gap, output logic [3:0] nib);
    spi_clk_in = 1'b1;
    wait_clk(1);
    nib = spi_data_out;
    check("data_oe", 32'(spi_data_oe), 32'hF);
    wait_clk(1 + gap);
    spi_clk_in = 1'b0;
    wait_clk(2 + gap);
  endtask

  task automatic read_byte(input int g0, input int g1, output logic [7:0] b);
    logic [3:0] hi;
    logic [3:0] lo;
    read_nibble(g0, hi);
    read_nibble(g1, lo);
    b = {hi, lo};
  endtask

  task automatic cs_begin();
    spi_select = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_end();
    spi_select = 1'b1;
    wait_clk(4);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_oe", 32'(spi_data_oe), 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] b;
    cs_begin();
    if (!v.skip_cmd) send_cmd(8'hEB);
    send_addr(v.addr, 6);
    sck_pulse(v.mode[7:4], 0);
    sck_pulse(v.mode[3:0], 0);
    check($sformatf("v%0d_mem_addr_start", idx), 32'(mem_addr), 32'(v.addr[11:0]));
    check($sformatf("v%0d_cont", idx), 32'(continuous), 32'(v.cont));
    for (int i = 0; i < 4; i++) sck_pulse(4'h0, 0);
    read_byte(0, 0, b);
    check($sformatf("v%0d_byte0", idx), 32'(b), 32'(v.b0));
    check($sformatf("v%0d_mem_addr_next", idx), 32'(mem_addr), 32'(v.a1));
    read_byte(0, 1, b);
    check($sformatf("v%0d_byte1", idx), 32'(b), 32'(v.b1));
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'h1);
    cs_end();
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] e;
    checks = 0;
    errors = 0;
    oe_or  = '0;
    mr_or  = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'(i * 7 + 3) ^ 8'(i >> 4);
    rom[12'h010] = 8'h5A;
    rom[12'h011] = 8'hC3;
    rom[12'hFFF] = 8'h3C;
    rom[12'h000] = 8'h96;
    rom[12'h234] = 8'hE1;
    rom[12'h235] = 8'h7F;

    vecs[0] = '{1'b0, 24'h100010, 8'hFF, 8'h5A, 8'hC3, 12'h011, 1'b0};
    vecs[1] = '{1'b0, 24'h100010, 8'hA0, 8'h5A, 8'hC3, 12'h011, 1'b1};
    vecs[2] = '{1'b1, 24'h000FFF, 8'hA0, 8'h3C, 8'h96, 12'h000, 1'b1};
    vecs[3] = '{1'b1, 24'hABC234, 8'h5F, 8'hE1, 8'h7F, 12'h235, 1'b0};
    vecs[4] = '{1'b0, 24'h000234, 8'hFF, 8'hE1, 8'h7F, 12'h235, 1'b0};

    // reset state
    reset       = 1'b1;
    spi_select  = 1'b1;
    spi_clk_in  = 1'b0;
    spi_data_in = 4'h0;
    wait_clk(3);
    check("rst_data_out", 32'(spi_data_out), 32'h0);
    check("rst_oe", 32'(spi_data_oe), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_cont", 32'(continuous), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    wait_clk(4);

    // unknown command is ignored for the whole CS window
    cs_begin();
    oe_or = '0;
    mr_or = 1'b0;
    send_cmd(8'h03);
    check("ign_busy", 32'(busy), 32'h1);
    send_addr(24'h000010, 6);
    send_mode_dummy(8'hFF);
    for (int i = 0; i < 4; i++) sck_pulse(4'h0, 0);
    check("ign_oe_never", 32'(oe_or), 32'h0);
    check("ign_mem_read_never", 32'(mr_or), 32'h0);
    cs_end();

    // table-driven transactions
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // CS released after three address nibbles
    cs_begin();
    send_cmd(8'hEB);
    send_addr(24'h123456, 3);
    check("abort_busy_before", 32'(busy), 32'h1);
    spi_select = 1'b1;
    wait_clk(3);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_oe", 32'(spi_data_oe), 32'h0);
    wait_clk(2);

    // reset while streaming with CS still low
    cs_begin();
    send_cmd(8'hEB);
    send_addr(24'h000010, 6);
    send_mode_dummy(8'hFF);
    read_byte(0, 0, b);
    check("rstdata_byte0", 32'(b), 32'h5A);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    check("rstdata_data_out", 32'(spi_data_out), 32'h0);
    check("rstdata_oe", 32'(spi_data_oe), 32'h0);
    check("rstdata_mem_addr", 32'(mem_addr), 32'h0);
    check("rstdata_mem_read", 32'(mem_read), 32'h0);
    check("rstdata_cont", 32'(continuous), 32'h0);
    check("rstdata_busy", 32'(busy), 32'h0);
    oe_or = '0;
    mr_or = 1'b0;
    for (int i = 0; i < 6; i++) sck_pulse(4'hE, 0);
    check("rstdata_oe_quiet", 32'(oe_or), 32'h0);
    check("rstdata_mem_read_quiet", 32'(mr_or), 32'h0);
    check("rstdata_busy_quiet", 32'(busy), 32'h0);
    cs_end();

    // 64-byte burst at clk/4 with random stretches, crossing 0x7FF -> 0x800
    for (int i = 0; i < 64; i++) exp_q.push_back(rom[12'(12'h7F0 + i)]);
    cs_begin();
    send_cmd(8'hEB);
    send_addr(24'h0007F0, 6);
    send_mode_dummy(8'hFF);
    for (int i = 0; i < 64; i++) begin
      read_byte(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), b);
      e = exp_q.pop_front();
      check($sformatf("burst_byte%0d", i), 32'(b), 32'(e));
    end
    check("burst_mem_addr", 32'(mem_addr), 32'h830);
    cs_end();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
